response_sender: RTL and testbench
==================================

# response_sender

Returns each sensor response to the Client as two serial bytes over the UART transmitter: first the response code, then the data byte. It sits between the sensor-decoding logic, which produces one 16-bit response per request, and the UART TX core. It is the outbound counterpart of the two-byte request intake (request code, then address). One response can be buffered while another is on the wire.

## Interface
- `GAP_CYCLES`, default 0: idle clock cycles inserted between the code byte and the data byte (0 to 65535).
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `response_valid`  in  1  a response is offered on `response_code`/`response_data`.
- `response_code`  in  8  response code byte; sent first.
- `response_data`  in  8  payload byte; sent second.
- `response_ready`  out  1  high when the holding register is empty; a transfer happens when valid and ready are both high on a clock edge.
- `tx_busy`  in  1  UART TX is shifting a byte. It rises 1–2 cycles after `tx_start` and falls when the stop bit completes.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_data`  out  8  byte to transmit; stable from the `tx_start` pulse until `tx_busy` falls.
- `busy`  out  1  high whenever a response is held or being transmitted.

## Operation
- Holding register: 16 bits plus a `full` flag.
  - Filled on an accepted transfer.
  - Emptied when the FSM leaves `IDLE` with the contents copied into the working register.
  - `response_ready = !full`.
- FSM states and transitions:
  - `IDLE`: if `full` and `!tx_busy`, move the holding register to the working register, clear `full`, go to `START_CODE`.
  - `START_CODE`: drive `tx_data = code`, pulse `tx_start`, go to `WAIT_CODE_HI`.
  - `WAIT_CODE_HI`: wait for `tx_busy = 1`, then go to `WAIT_CODE_LO`.
  - `WAIT_CODE_LO`: wait for `tx_busy = 0`. Go to `GAP` if `GAP_CYCLES > 0`, else go to `START_DATA`.
  - `GAP`: count `GAP_CYCLES` cycles, then go to `START_DATA`.
  - `START_DATA`: drive `tx_data = data`, pulse `tx_start`, go to `WAIT_DATA_HI`.
  - `WAIT_DATA_HI`: wait for `tx_busy = 1`, then go to `WAIT_DATA_LO`.
  - `WAIT_DATA_LO`: wait for `tx_busy = 0`, then go to `IDLE`.
- Any undefined state encoding returns to `IDLE`.
- Accept during transmission: a new response may be accepted in any state while `full = 0`. It is sent immediately after the current pair finishes.
- Simultaneous accept and drain in `IDLE`: cannot occur, because ready is low while `full = 1`. A response accepted while the FSM is in `IDLE` with `full = 0` is drained on the next cycle.
- `tx_busy` already high in `IDLE` (another TX user): the FSM holds in `IDLE` until it is low. The code byte is never pulsed onto a busy transmitter.
- Byte order is fixed: code, then data. The two bytes are never split by another response.
- Gap counter: 16-bit, counts from 0 to `GAP_CYCLES - 1`, cleared on entry to `GAP`.

## Timing
- Reset values:
  - `tx_start = 0`, `tx_data = 8'h00`, `busy = 0`, `response_ready = 1`.
  - `full = 0`, FSM in `IDLE`, gap counter 0.
- Reset asserted mid-transmission aborts immediately: the FSM is in `IDLE`, the holding register is empty, and no further `tx_start` pulses occur. A byte already in the UART core completes on its own.
- Latency: response accepted at edge N with `tx_busy = 0` produces:
  - `IDLE` drain at edge N+1;
  - `tx_start` high during the cycle following edge N+2 (state `START_CODE`).
- Code-to-data gap: `tx_start` for the data byte is high exactly `GAP_CYCLES + 1` cycles after the edge at which `tx_busy` is sampled low in `WAIT_CODE_LO`.
- `tx_start` is registered and is high for exactly one cycle per byte.
- `busy` is registered and equals (`full` or FSM not in `IDLE`).

## Structure
- Shared package (`response_pkg`) holds:
  - the state enumeration (3-bit encoding);
  - `RESPONSE_WIDTH = 16`;
  - the byte-order constants `CODE_BYTE = 0` and `DATA_BYTE = 1`.
- Sub-module `response_holding_reg`: the single-entry valid/ready buffer (load, drain, `full`). The FSM, working register and gap counter stay in the top module.

## Test plan
- Single response: code `8'h01`, data `8'h2A`, TX model with 10-cycle busy, `GAP_CYCLES = 0` -> `tx_start` pulses carry `8'h01` then `8'h2A`. `busy` falls the cycle after the second `tx_busy` fall. Exactly two pulses.
- Back-to-back: `{8'h01,8'h2A}` then `{8'h02,8'h17}` offered with valid held high -> second accepted while the first is on the wire. The order on the wire is 01, 2A, 02, 17. `response_ready` is low only while the holding register is full.
- Gap: `GAP_CYCLES = 5` -> the data-byte `tx_start` is high 6 cycles after `tx_busy` is sampled low following the code byte.
- Busy transmitter: `tx_busy` forced high for 20 cycles before the response is accepted -> no `tx_start` until `tx_busy` falls. The first pulse comes 2 cycles after the fall.
- Reset mid-operation: assert `reset` while in `WAIT_CODE_LO` with the holding register full -> outputs return to their reset values immediately. No data byte is sent and the held response is discarded. The next accepted response is sent normally.

Source files
------------

// File: rtl/response_pkg.sv
`default_nettype none
// ============================================================================
// Module      : response_pkg
// Description : Shared types and constants for the two-byte response sender:
//               FSM state encoding, response width and byte-order indices.
// Revision    : 1.0 - initial release
// ============================================================================
package response_pkg;

    localparam int RESPONSE_WIDTH = 16;
    localparam int BYTE_WIDTH     = 8;

    // Byte order on the wire: the code byte always precedes the data byte.
    localparam int CODE_BYTE = 0;
    localparam int DATA_BYTE = 1;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_START_CODE   = 3'd1,
        ST_WAIT_CODE_HI = 3'd2,
        ST_WAIT_CODE_LO = 3'd3,
        ST_GAP          = 3'd4,
        ST_START_DATA   = 3'd5,
        ST_WAIT_DATA_HI = 3'd6,
        ST_WAIT_DATA_LO = 3'd7
    } state_e;

    // Select one byte of a packed {code, data} response by its wire position.
    function automatic logic [BYTE_WIDTH-1:0] response_byte(
        input logic [RESPONSE_WIDTH-1:0] resp,
        input int                        idx
    );
        if (idx == CODE_BYTE) begin
            return resp[RESPONSE_WIDTH-1:BYTE_WIDTH];
        end
        return resp[BYTE_WIDTH-1:0];
    endfunction

endpackage : response_pkg
`default_nettype wire

// File: rtl/response_holding_reg.sv
`default_nettype none
// ============================================================================
// Module      : response_holding_reg
// Description : Single-entry valid/ready buffer for one packed response.
//               Loads on a valid/ready handshake, empties when drained.
// Revision    : 1.0 - initial release
// ============================================================================
module response_holding_reg
    import response_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      valid_i,
    input  logic [RESPONSE_WIDTH-1:0] data_i,
    input  logic                      drain_i,
    output logic                      ready_o,
    output logic [RESPONSE_WIDTH-1:0] data_o,
    output logic                      full_o,
    output logic                      full_next_o
);

    logic                      full_q;
    logic                      full_d;
    logic [RESPONSE_WIDTH-1:0] data_q;
    logic [RESPONSE_WIDTH-1:0] data_d;
    logic                      w_accept;

    // A transfer only happens while the entry is empty, so load and drain
    // never coincide; load still wins for robustness.
    assign w_accept = valid_i && !full_q;

    // Next-state for the entry: load on handshake, clear on drain.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (w_accept) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    // Entry storage with asynchronous reset to empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o     = !full_q;
    assign data_o      = data_q;
    assign full_o      = full_q;
    assign full_next_o = full_d;

endmodule : response_holding_reg
`default_nettype wire

// File: rtl/response_sender.sv
`default_nettype none
// ============================================================================
// Module      : response_sender
// Description : Sends each 16-bit sensor response to the UART TX core as two
//               bytes (code, then data) with an optional idle gap between
//               them. One further response can be held while a pair is sent.
// Revision    : 1.0 - initial release
// ============================================================================
module response_sender
    import response_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  response_valid,
    input  logic [BYTE_WIDTH-1:0] response_code,
    input  logic [BYTE_WIDTH-1:0] response_data,
    output logic                  response_ready,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [BYTE_WIDTH-1:0] tx_data,
    output logic                  busy
);

    // Last count value of the gap counter; unused when no gap is configured.
    localparam logic [15:0] c_gap_last = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_e                    state_q;
    state_e                    state_d;
    logic [RESPONSE_WIDTH-1:0] work_q;
    logic [RESPONSE_WIDTH-1:0] work_d;
    logic [15:0]               gap_q;
    logic [15:0]               gap_d;
    logic                      tx_start_q;
    logic                      tx_start_d;
    logic [BYTE_WIDTH-1:0]     tx_data_q;
    logic [BYTE_WIDTH-1:0]     tx_data_d;
    logic                      busy_q;
    logic                      busy_d;

    logic                      w_drain;
    logic                      w_full;
    logic                      w_full_next;
    logic [RESPONSE_WIDTH-1:0] w_hold_data;

    response_holding_reg u_hold (
        .clock       (clock),
        .reset       (reset),
        .valid_i     (response_valid),
        .data_i      ({response_code, response_data}),
        .drain_i     (w_drain),
        .ready_o     (response_ready),
        .data_o      (w_hold_data),
        .full_o      (w_full),
        .full_next_o (w_full_next)
    );

    // Next-state, working register, gap counter and registered TX outputs.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        gap_d      = gap_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        w_drain    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Never start a pair on a transmitter another user holds.
                if (w_full && !tx_busy) begin
                    w_drain = 1'b1;
                    work_d  = w_hold_data;
                    state_d = ST_START_CODE;
                end
            end
            ST_START_CODE: begin
                tx_start_d = 1'b1;
                tx_data_d  = response_byte(work_q, CODE_BYTE);
                state_d    = ST_WAIT_CODE_HI;
            end
            ST_WAIT_CODE_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_CODE_LO;
                end
            end
            ST_WAIT_CODE_LO: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        gap_d   = 16'd0;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_START_DATA;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == c_gap_last) begin
                    state_d = ST_START_DATA;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            ST_START_DATA: begin
                tx_start_d = 1'b1;
                tx_data_d  = response_byte(work_q, DATA_BYTE);
                state_d    = ST_WAIT_DATA_HI;
            end
            ST_WAIT_DATA_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DATA_LO;
                end
            end
            ST_WAIT_DATA_LO: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered from next-state values so busy tracks the current state.
        busy_d = w_full_next || (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any pair in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            gap_q      <= 16'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            gap_q      <= gap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;

endmodule : response_sender
`default_nettype wire

// File: tb/tb_response_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_response_sender
// Description : Self-checking bench for response_sender. Two instances (no
//               gap and a 5-cycle gap) each drive a behavioural UART TX model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_response_sender;

    localparam int GAP0  = 0;
    localparam int GAP1  = 5;
    localparam int LOG_N = 1024;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       valid_v;
    logic [7:0]       code_a [2];
    logic [7:0]       data_a [2];
    logic [1:0]       ready_v;
    logic [1:0]       tx_busy_v;
    logic [1:0]       tx_start_v;
    logic [1:0][7:0]  tx_data_v;
    logic [1:0]       busy_v;
    logic [1:0]       tx_force;

    int cyc = 0;
    int tx_cnt [2] = '{0, 0};
    int tx_len [2];

    // Transmit log written only by the monitor.
    logic [7:0] byte_log  [2][LOG_N];
    int         edge_log  [2][LOG_N];
    int         fall_log  [2][LOG_N];
    int         n_starts  [2] = '{0, 0};
    int         n_falls   [2] = '{0, 0};
    int         pw_err    [2] = '{0, 0};
    int         busy_fall [2] = '{0, 0};
    logic [1:0] prev_st = 2'b00;
    logic [1:0] prev_tb = 2'b00;
    logic [1:0] prev_bz = 2'b00;

    int n_tests = 0;
    int n_fail  = 0;

    response_sender #(.GAP_CYCLES(GAP0)) dut0 (
        .clock          (clock),
        .reset          (reset),
        .response_valid (valid_v[0]),
        .response_code  (code_a[0]),
        .response_data  (data_a[0]),
        .response_ready (ready_v[0]),
        .tx_busy        (tx_busy_v[0]),
        .tx_start       (tx_start_v[0]),
        .tx_data        (tx_data_v[0]),
        .busy           (busy_v[0])
    );

    response_sender #(.GAP_CYCLES(GAP1)) dut1 (
        .clock          (clock),
        .reset          (reset),
        .response_valid (valid_v[1]),
        .response_code  (code_a[1]),
        .response_data  (data_a[1]),
        .response_ready (ready_v[1]),
        .tx_busy        (tx_busy_v[1]),
        .tx_start       (tx_start_v[1]),
        .tx_data        (tx_data_v[1]),
        .busy           (busy_v[1])
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // UART TX model: busy rises one cycle after a start pulse and stays high
    // for tx_len cycles; tx_force emulates another user holding the TX.
    assign tx_busy_v[0] = (tx_cnt[0] != 0) || tx_force[0];
    assign tx_busy_v[1] = (tx_cnt[1] != 0) || tx_force[1];

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (tx_start_v[d]) tx_cnt[d] <= tx_len[d];
            else if (tx_cnt[d] != 0) tx_cnt[d] <= tx_cnt[d] - 1;
        end
    end

    // Monitor: log start pulses (byte, edge), tx_busy fall sampling edges and
    // busy deassertion edges; count pulses wider than one cycle.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (tx_start_v[d]) begin
                if (n_starts[d] < LOG_N) begin
                    byte_log[d][n_starts[d]] <= tx_data_v[d];
                    edge_log[d][n_starts[d]] <= cyc;
                end
                n_starts[d] <= n_starts[d] + 1;
                if (prev_st[d]) pw_err[d] <= pw_err[d] + 1;
            end
            if (prev_tb[d] && !tx_busy_v[d] && n_falls[d] < LOG_N) begin
                fall_log[d][n_falls[d]] <= cyc + 1;
                n_falls[d] <= n_falls[d] + 1;
            end
            if (prev_bz[d] && !busy_v[d]) busy_fall[d] <= cyc;
            prev_st[d] <= tx_start_v[d];
            prev_tb[d] <= tx_busy_v[d];
            prev_bz[d] <= busy_v[d];
        end
    end

    typedef struct {
        int         dut;
        logic [7:0] code;
        logic [7:0] data;
        logic [7:0] exp_b0;
        logic [7:0] exp_b1;
        int         exp_lat;
        int         exp_gap;
    } vec_t;

    vec_t vecs [4];

    function automatic vec_t mk_vec(input int d, input logic [7:0] c, input logic [7:0] dt, input int gap);
        vec_t v;
        v.dut     = d;
        v.code    = c;
        v.data    = dt;
        v.exp_b0  = c;
        v.exp_b1  = dt;
        v.exp_lat = 2;
        v.exp_gap = gap + 1;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Advance to just after the next falling edge; all driving/sampling here.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] c, input logic [7:0] dt, output int acc);
        bit done;
        done       = 1'b0;
        acc        = -1;
        valid_v[d] = 1'b1;
        code_a[d]  = c;
        data_a[d]  = dt;
        for (int k = 0; k < 400 && !done; k++) begin
            done = ready_v[d];
            step();
            if (done) acc = cyc;
        end
        valid_v[d] = 1'b0;
        if (!done) timeout_fail("send handshake");
    endtask

    task automatic wait_starts(input int d, input int target);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            if (n_starts[d] >= target) ok = 1'b1;
            else step();
        end
        if (!ok) timeout_fail("wait tx_start");
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            if (!busy_v[d] && !tx_busy_v[d]) ok = 1'b1;
            else step();
        end
        if (!ok) timeout_fail("wait idle");
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, " tx_start"}, int'(tx_start_v[d]), 0);
            check({tag, " tx_data"},  int'(tx_data_v[d]),  0);
            check({tag, " busy"},     int'(busy_v[d]),     0);
            check({tag, " ready"},    int'(ready_v[d]),    1);
        end
    endtask

    initial begin
        int         acc, acc2, n0, f0, rel;
        logic [7:0] exp_q [$];

        reset     = 1'b1;
        valid_v   = 2'b00;
        tx_force  = 2'b00;
        code_a    = '{8'h00, 8'h00};
        data_a    = '{8'h00, 8'h00};
        tx_len    = '{10, 10};

        vecs[0] = mk_vec(0, 8'h01, 8'h2A, GAP0);
        vecs[1] = mk_vec(0, 8'hFF, 8'h00, GAP0);
        vecs[2] = mk_vec(1, 8'h01, 8'h2A, GAP1);
        vecs[3] = mk_vec(1, 8'h80, 8'h7F, GAP1);

        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Single responses from idle: byte order, start latency, gap, busy.
        for (int i = 0; i < 4; i++) begin
            int d;
            d  = vecs[i].dut;
            n0 = n_starts[d];
            f0 = n_falls[d];
            send(d, vecs[i].code, vecs[i].data, acc);
            wait_starts(d, n0 + 2);
            wait_idle(d);
            repeat (20) step();
            check("single pulse count", n_starts[d] - n0, 2);
            check("single code byte", int'(byte_log[d][n0]), int'(vecs[i].exp_b0));
            check("single data byte", int'(byte_log[d][n0 + 1]), int'(vecs[i].exp_b1));
            check("accept to code start", edge_log[d][n0] - acc, vecs[i].exp_lat);
            check("code fall to data start", edge_log[d][n0 + 1] - fall_log[d][f0], vecs[i].exp_gap);
            check("busy fall at data fall", busy_fall[d], fall_log[d][f0 + 1]);
        end

        // Back-to-back with valid held: second accepted while first on wire.
        n0 = n_starts[0];
        send(0, 8'h01, 8'h2A, acc);
        send(0, 8'h02, 8'h17, acc2);
        check("b2b second accept edge", acc2 - acc, 2);
        check("b2b ready low while held", int'(ready_v[0]), 0);
        wait_starts(0, n0 + 2);
        check("b2b ready low during first data", int'(ready_v[0]), 0);
        check("b2b accepted before first data", int'(acc2 < edge_log[0][n0 + 1]), 1);
        wait_starts(0, n0 + 3);
        check("b2b ready after drain", int'(ready_v[0]), 1);
        wait_starts(0, n0 + 4);
        wait_idle(0);
        check("b2b byte0", int'(byte_log[0][n0]),     8'h01);
        check("b2b byte1", int'(byte_log[0][n0 + 1]), 8'h2A);
        check("b2b byte2", int'(byte_log[0][n0 + 2]), 8'h02);
        check("b2b byte3", int'(byte_log[0][n0 + 3]), 8'h17);

        // Transmitter held by another user: no pulse until it is released.
        n0 = n_starts[0];
        tx_force[0] = 1'b1;
        repeat (20) step();
        send(0, 8'hA5, 8'h5A, acc);
        repeat (5) step();
        check("forced busy no start", n_starts[0] - n0, 0);
        tx_force[0] = 1'b0;
        rel = cyc;
        wait_starts(0, n0 + 2);
        wait_idle(0);
        check("forced busy start after release", edge_log[0][n0] - rel, 2);
        check("forced busy code", int'(byte_log[0][n0]), 8'hA5);
        check("forced busy data", int'(byte_log[0][n0 + 1]), 8'h5A);

        // Reset while waiting for the code byte to finish with one held.
        n0 = n_starts[0];
        send(0, 8'h55, 8'h66, acc);
        send(0, 8'h77, 8'h88, acc2);
        wait_starts(0, n0 + 1);
        for (int k = 0; k < 50 && !tx_busy_v[0]; k++) step();
        step();
        step();
        check("pre-reset held full", int'(ready_v[0]), 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("async reset");
        step();
        step();
        reset = 1'b0;
        wait_idle(0);
        repeat (30) step();
        check("reset abort pulse count", n_starts[0] - n0, 1);
        check("reset abort busy", int'(busy_v[0]), 0);
        n0 = n_starts[0];
        send(0, 8'h3C, 8'hC3, acc);
        wait_starts(0, n0 + 2);
        wait_idle(0);
        check("post-reset code", int'(byte_log[0][n0]), 8'h3C);
        check("post-reset data", int'(byte_log[0][n0 + 1]), 8'hC3);
        check("post-reset latency", edge_log[0][n0] - acc, 2);

        // Random traffic against an in-order byte-stream model.
        n0 = n_starts[1];
        for (int r = 0; r < 25; r++) begin
            logic [7:0] c, dt;
            c  = 8'($urandom);
            dt = 8'($urandom);
            tx_len[1] = int'($urandom_range(1, 12));
            exp_q.push_back(c);
            exp_q.push_back(dt);
            send(1, c, dt, acc);
            repeat (int'($urandom_range(0, 3))) step();
        end
        wait_starts(1, n0 + exp_q.size());
        wait_idle(1);
        repeat (20) step();
        check("random byte count", n_starts[1] - n0, exp_q.size());
        for (int k = 0; k < exp_q.size() && (n0 + k) < LOG_N; k++) begin
            check($sformatf("random byte %0d", k), int'(byte_log[1][n0 + k]), int'(exp_q[k]));
        end

        check("dut0 single-cycle pulses", pw_err[0], 0);
        check("dut1 single-cycle pulses", pw_err[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_response_sender
`default_nettype wire
